dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Load/store sequencer and two-port arbiter in front of the single-port data memory. It shares that memory between the core load/store port (`c_*`) and the program/debug loader port (`l_*`) using round-robin arbitration. The data memory writes only one byte lane per enabled cycle, so this block splits halfword and word stores into one-hot lane writes, one per cycle. It also extracts and extends load data, and rejects misaligned or out-of-range accesses.

## Interface
- `ADDR_W`, default 10: word-index width of the data memory (1024 words).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `c_req`, `l_req` in 1: access request. Hold it, with all fields stable, until `*_gnt`.
- `c_we`, `l_we` in 1: 1 = store, 0 = load.
- `c_addr`, `l_addr` in 32: byte address.
- `c_size`, `l_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `c_uns`, `l_uns` in 1: zero-extend loads (1) or sign-extend (0).
- `c_wdata`, `l_wdata` in 32: store data, right-aligned.
- `c_gnt`, `l_gnt` out 1: combinational one-cycle acceptance pulse.
- `c_done`, `l_done` out 1: registered one-cycle completion pulse.
- `c_err`, `l_err` out 1: valid with `*_done`; 1 = access rejected.
- `c_rdata`, `l_rdata` out 32: both driven from one shared result register; valid with the owner's `*_done` on a load.
- `mem_a` out 32: word index, zero-extended.
- `mem_wd` out 32: lane-aligned write data.
- `mem_we` out 1: memory write enable.
- `mem_wm` out 4: byte-lane mask. Always one-hot when `mem_we`=1, otherwise 0.
- `mem_rd` in 32: combinational read data from the memory.

## Operation
- States: IDLE, LD, ST.
- IDLE, arbitration:
  - If any `*_req` is high, grant one requester: assert its `*_gnt` and latch its fields at the edge.
  - If both request, the port not granted last wins.
  - After reset, "last granted" = loader, so the core wins the first tie.
  - The pointer updates on every grant.
- Error check, on the granted request:
  - size=11 is an error.
  - size=01 with addr[0]=1 is an error.
  - size=10 with addr[1:0]≠0 is an error.
  - Any bit of addr[31:ADDR_W+2] set is an error.
  - On error: no memory access. The owner's done=1 and err=1 next cycle. State stays IDLE.
- Legal load: go to LD. In LD:
  - `mem_a` = latched addr[ADDR_W+1:2], `mem_we`=0.
  - At the edge, the result register captures the extracted data:
    - byte: `mem_rd` lane addr[1:0], i.e. bits [8k+7:8k];
    - half: lane pair selected by addr[1];
    - word: all of `mem_rd`;
    - extension per `uns`.
  - Owner's done=1, err=0. Return to IDLE.
- Legal store: go to ST with lane counter = addr[1:0] and remaining = 1, 2 or 4 (byte/half/word). Each ST cycle:
  - `mem_we`=1 and `mem_wm` = one-hot(lane);
  - `mem_a` = word index;
  - `mem_wd` = wdata << 8·addr[1:0];
  - lane increments, remaining decrements.
  - After the last lane: owner's done=1, err=0, IDLE.
  - The result register is unchanged by stores.
- Outside LD/ST: `mem_a`=0, `mem_we`=0, `mem_wm`=0.
- Requests arriving while LD or ST is active wait; no gnt is asserted outside IDLE.

## Timing
- Grant in cycle T (IDLE).
- Load: LD at T+1, done at T+2.
- Store: ST at T+1 … T+n for n = 1/2/4 lanes, done at T+n+1.
- Error: done/err at T+1.
- The next grant is possible in the same cycle as the previous done (the FSM is back in IDLE).
- Done of one access and gnt of the next may coincide for different ports.
- Reset values:
  - state IDLE;
  - all `*_done`, `*_err` = 0;
  - result register = 0, so `*_rdata` = 0;
  - `mem_we`=0, `mem_wm`=0, `mem_a`=0, `mem_wd`=0;
  - pointer = loader.
- Reset mid-ST: remaining lanes are abandoned and lanes already written stay written. No done is issued, and the next cycle is IDLE.
- Reset while `*_req` is high: no gnt in the reset cycle.
- Lane counter never wraps: legal halfword stores start at lane 0 or 2, words at lane 0.

## Test plan
- Core word store 0xDEADBEEF @0x10, then load: 4 ST cycles with `mem_a`=4 and `mem_wm` 0001, 0010, 0100, 1000. `c_done` at T+5. Load returns 0xDEADBEEF at T+2.
- Byte loads from word 0x80FF7F01: byte @0x3 signed → 0xFFFFFF80; byte @0x3 unsigned → 0x00000080; half @0x2 signed → 0xFFFF80FF; byte @0x1 signed → 0x0000007F.
- Half store 0xAB12 @0x6 over word 0x11223344 @0x4: `mem_wm` 0100 then 1000, `mem_wd`=0xAB120000. Reload word → 0xAB123344.
- Simultaneous `c_req`/`l_req` after reset: `c_gnt` first, then `l_gnt`; alternation continues while both are held.
- Errors produce done+err at T+1 with `mem_we` never asserted:
  - word @0x2;
  - half @0x5;
  - size=11;
  - addr 0x1000 with ADDR_W=10.
- `rst` asserted in the 2nd ST cycle of a word store: only lane 0 is written, no `c_done`, IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Load/store sequencer and round-robin arbiter sharing a single-port, byte-lane-write
// data memory between the core port (c_*) and the loader port (l_*).
module dmem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_size,
    input  logic        c_uns,
    input  logic [31:0] c_wdata,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [1:0]  l_size,
    input  logic        l_uns,
    input  logic [31:0] l_wdata,
    output logic        c_gnt,
    output logic        l_gnt,
    output logic        c_done,
    output logic        l_done,
    output logic        c_err,
    output logic        l_err,
    output logic [31:0] c_rdata,
    output logic [31:0] l_rdata,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [3:0]  mem_wm,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LD   = 2'd1,
        S_ST   = 2'd2
    } state_t;

    function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | (|addr[31:ADDR_W+2]);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t              state_r, state_nxt_s;
    logic                last_r;          // 1 = loader was granted last
    logic                own_r, own_nxt_s;
    logic [ADDR_W+1:0]   addr_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [31:0]         wdata_r;
    logic [1:0]          lane_r, lane_nxt_s;
    logic [2:0]          rem_r, rem_nxt_s;
    logic [31:0]         result_r;
    logic                c_done_r, l_done_r, c_err_r, l_err_r;
    logic [31:0]         mem_a_r, mem_wd_r;
    logic                mem_we_r;
    logic [3:0]          mem_wm_r;

    logic                gnt_s, pick_l_s;
    logic                g_we_s, g_uns_s, g_err_s;
    logic [31:0]         g_addr_s, g_wdata_s;
    logic [1:0]          g_size_s;
    logic                done_nxt_s, err_nxt_s, cap_s;
    logic [31:0]         mem_a_nxt_s, mem_wd_nxt_s;
    logic                mem_we_nxt_s;
    logic [3:0]          mem_wm_nxt_s;

    // Round-robin pick; a tie goes to the port that was not granted last.
    always_comb begin
        gnt_s    = 1'b0;
        pick_l_s = 1'b0;
        if ((state_r == S_IDLE) && !rst) begin
            if (c_req && l_req) begin
                gnt_s    = 1'b1;
                pick_l_s = ~last_r;
            end else if (c_req) begin
                gnt_s    = 1'b1;
                pick_l_s = 1'b0;
            end else if (l_req) begin
                gnt_s    = 1'b1;
                pick_l_s = 1'b1;
            end else begin
                gnt_s    = 1'b0;
                pick_l_s = 1'b0;
            end
        end else begin
            gnt_s    = 1'b0;
            pick_l_s = 1'b0;
        end
    end

    assign g_we_s    = pick_l_s ? l_we    : c_we;
    assign g_addr_s  = pick_l_s ? l_addr  : c_addr;
    assign g_size_s  = pick_l_s ? l_size  : c_size;
    assign g_uns_s   = pick_l_s ? l_uns   : c_uns;
    assign g_wdata_s = pick_l_s ? l_wdata : c_wdata;
    assign g_err_s   = access_err(g_addr_s, g_size_s);

    assign c_gnt = gnt_s & ~pick_l_s;
    assign l_gnt = gnt_s & pick_l_s;

    // Next state plus the memory-port values for the cycle that follows.
    always_comb begin
        state_nxt_s  = state_r;
        own_nxt_s    = own_r;
        lane_nxt_s   = lane_r;
        rem_nxt_s    = rem_r;
        done_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        cap_s        = 1'b0;
        mem_a_nxt_s  = 32'd0;
        mem_wd_nxt_s = 32'd0;
        mem_we_nxt_s = 1'b0;
        mem_wm_nxt_s = 4'd0;
        case (state_r)
            S_IDLE: begin
                if (gnt_s) begin
                    own_nxt_s = pick_l_s;
                    if (g_err_s) begin
                        done_nxt_s = 1'b1;
                        err_nxt_s  = 1'b1;
                    end else if (g_we_s) begin
                        state_nxt_s  = S_ST;
                        lane_nxt_s   = g_addr_s[1:0];
                        case (g_size_s)
                            2'b00:   rem_nxt_s = 3'd1;
                            2'b01:   rem_nxt_s = 3'd2;
                            default: rem_nxt_s = 3'd4;
                        endcase
                        mem_a_nxt_s  = {{(30-ADDR_W){1'b0}}, g_addr_s[ADDR_W+1:2]};
                        mem_we_nxt_s = 1'b1;
                        mem_wm_nxt_s = 4'b0001 << g_addr_s[1:0];
                        mem_wd_nxt_s = g_wdata_s << {g_addr_s[1:0], 3'b000};
                    end else begin
                        state_nxt_s = S_LD;
                        mem_a_nxt_s = {{(30-ADDR_W){1'b0}}, g_addr_s[ADDR_W+1:2]};
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LD: begin
                cap_s       = 1'b1;
                done_nxt_s  = 1'b1;
                state_nxt_s = S_IDLE;
            end
            S_ST: begin
                lane_nxt_s = lane_r + 2'd1;
                rem_nxt_s  = rem_r - 3'd1;
                if (rem_r == 3'd1) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    mem_a_nxt_s  = {{(30-ADDR_W){1'b0}}, addr_r[ADDR_W+1:2]};
                    mem_we_nxt_s = 1'b1;
                    mem_wm_nxt_s = 4'b0001 << (lane_r + 2'd1);
                    mem_wd_nxt_s = wdata_r << {addr_r[1:0], 3'b000};
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, arbitration pointer and latched request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            last_r  <= 1'b1;
            own_r   <= 1'b0;
            addr_r  <= {(ADDR_W+2){1'b0}};
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
            wdata_r <= 32'd0;
            lane_r  <= 2'd0;
            rem_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            own_r   <= own_nxt_s;
            lane_r  <= lane_nxt_s;
            rem_r   <= rem_nxt_s;
            if (gnt_s) begin
                last_r  <= pick_l_s;
                addr_r  <= g_addr_s[ADDR_W+1:0];
                size_r  <= g_size_s;
                uns_r   <= g_uns_s;
                wdata_r <= g_wdata_s;
            end
        end
    end

    // Registered completion, error and shared load-result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= 32'd0;
            c_done_r <= 1'b0;
            l_done_r <= 1'b0;
            c_err_r  <= 1'b0;
            l_err_r  <= 1'b0;
        end else begin
            if (cap_s) begin
                result_r <= load_extract(mem_rd, addr_r[1:0], size_r, uns_r);
            end
            c_done_r <= done_nxt_s & ~own_nxt_s;
            l_done_r <= done_nxt_s & own_nxt_s;
            c_err_r  <= err_nxt_s & ~own_nxt_s;
            l_err_r  <= err_nxt_s & own_nxt_s;
        end
    end

    // Registered memory-port drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_a_r  <= 32'd0;
            mem_wd_r <= 32'd0;
            mem_we_r <= 1'b0;
            mem_wm_r <= 4'd0;
        end else begin
            mem_a_r  <= mem_a_nxt_s;
            mem_wd_r <= mem_wd_nxt_s;
            mem_we_r <= mem_we_nxt_s;
            mem_wm_r <= mem_wm_nxt_s;
        end
    end

    assign c_done  = c_done_r;
    assign l_done  = l_done_r;
    assign c_err   = c_err_r;
    assign l_err   = l_err_r;
    assign c_rdata = result_r;
    assign l_rdata = result_r;
    assign mem_a   = mem_a_r;
    assign mem_wd  = mem_wd_r;
    // Reset kills a pending lane write in the same cycle so an interrupted store stops at once.
    assign mem_we  = mem_we_r & ~rst;
    assign mem_wm  = mem_wm_r & {4{~rst}};

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed steps then random accesses, checked against a
// byte-array memory model and per-access latency/lane expectations.
module tb_dmem_ctrl;
    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_uns, l_req, l_we, l_uns;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic [1:0]  c_size, l_size;
    logic        c_gnt, l_gnt, c_done, l_done, c_err, l_err;
    logic [31:0] c_rdata, l_rdata, mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [3:0]  mem_wm;

    int    n_checks = 0;
    int    n_errors = 0;
    string step = "init";

    logic [31:0] tb_mem [0:1023];
    logic        mem_clr;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] wq_a[$];
    logic [31:0] wq_wd[$];
    logic [3:0]  wq_wm[$];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size), .c_uns(c_uns), .c_wdata(c_wdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_size(l_size), .l_uns(l_uns), .l_wdata(l_wdata),
        .c_gnt(c_gnt), .l_gnt(l_gnt), .c_done(c_done), .l_done(l_done), .c_err(c_err), .l_err(l_err),
        .c_rdata(c_rdata), .l_rdata(l_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_wm(mem_wm), .mem_rd(mem_rd)
    );

    assign mem_rd = tb_mem[mem_a[ADDR_W-1:0]];

    // Byte-lane memory and write recorder.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'd0;
        end else if (mem_we) begin
            wq_a.push_back(mem_a);
            wq_wm.push_back(mem_wm);
            wq_wd.push_back(mem_wd);
            for (int k = 0; k < 4; k++)
                if (mem_wm[k]) tb_mem[mem_a[ADDR_W-1:0]][8*k +: 8] <= mem_wd[8*k +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s/%s: observed %h expected %h", step, tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] addr, input logic [1:0] size);
        int nb;
        if (size == 2'd3) return 1'b0;
        nb = 1 << size;
        return ((addr % nb) == 0) && (addr < (32'd4 << ADDR_W));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input bit uns);
        logic [31:0] v;
        int nb;
        nb = 1 << size;
        v  = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on one port, checked against the model.
    task automatic access(input bit port, input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        bit          ok;
        int          nb, n, lat, exp_lat, lane;
        logic        g, d;
        logic [31:0] exp_rd;
        ok     = legal(addr, size);
        nb     = 1 << size;
        exp_rd = ok ? model_load(addr, size, uns) : 32'd0;
        wq_a.delete(); wq_wm.delete(); wq_wd.delete();
        c_req = 1'b0; l_req = 1'b0;
        if (port) begin
            l_we = we; l_addr = addr; l_size = size; l_uns = uns; l_wdata = wdata; l_req = 1'b1;
        end else begin
            c_we = we; c_addr = addr; c_size = size; c_uns = uns; c_wdata = wdata; c_req = 1'b1;
        end
        #1;
        n = 0;
        g = port ? l_gnt : c_gnt;
        while (!g && n < 20) begin
            tick();
            n++;
            g = port ? l_gnt : c_gnt;
        end
        chk("gnt", 32'(g), 32'd1);
        chk("other_gnt", 32'(port ? c_gnt : l_gnt), 32'd0);
        tick();
        c_req = 1'b0; l_req = 1'b0;
        lat = 1;
        d = port ? l_done : c_done;
        while (!d && lat < 8) begin
            tick();
            lat++;
            d = port ? l_done : c_done;
        end
        exp_lat = !ok ? 1 : (we ? nb + 1 : 2);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("other_done", 32'(port ? c_done : l_done), 32'd0);
        err   = port ? l_err : c_err;
        rdata = port ? l_rdata : c_rdata;
        chk("err", 32'(err), 32'(!ok));
        if (ok && !we) chk("rdata", rdata, exp_rd);
        if (ok && we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            chk("nwrites", 32'(wq_a.size()), 32'(nb));
            for (int i = 0; i < nb && i < wq_a.size(); i++) begin
                lane = int'(addr % 4) + i;
                chk("wr_a", wq_a[i], addr >> 2);
                chk("wr_wm", 32'(wq_wm[i]), 32'd1 << lane);
                chk("wr_wd", wq_wd[i], wdata << (8 * (addr % 4)));
            end
        end else begin
            chk("nwrites", 32'(wq_a.size()), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd, ra;
        logic        er;
        bit          p, w, u;
        logic [1:0]  sz;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        rst = 1'b1; mem_clr = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'd0; c_size = 2'd2; c_uns = 1'b0; c_wdata = 32'd0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 32'd0; l_size = 2'd2; l_uns = 1'b0; l_wdata = 32'd0;

        step = "reset";
        c_req = 1'b1;
        repeat (2) tick();
        chk("c_gnt_in_rst", 32'(c_gnt), 32'd0);
        chk("c_done", 32'(c_done), 32'd0);
        chk("l_done", 32'(l_done), 32'd0);
        chk("c_err", 32'(c_err), 32'd0);
        chk("l_err", 32'(l_err), 32'd0);
        chk("c_rdata", c_rdata, 32'd0);
        chk("l_rdata", l_rdata, 32'd0);
        chk("mem_we", 32'(mem_we), 32'd0);
        chk("mem_wm", 32'(mem_wm), 32'd0);
        chk("mem_a", mem_a, 32'd0);
        chk("mem_wd", mem_wd, 32'd0);
        c_req = 1'b0; rst = 1'b0; mem_clr = 1'b0;
        tick();

        step = "word_store_load";
        access(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, er);
        access(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, rd, er);
        chk("ld_word", rd, 32'hDEADBEEF);

        step = "byte_loads";
        access(1'b1, 1'b1, 32'h0, 2'd2, 1'b0, 32'h80FF7F01, rd, er);
        access(1'b0, 1'b0, 32'h3, 2'd0, 1'b0, 32'd0, rd, er);
        chk("b3_signed", rd, 32'hFFFFFF80);
        access(1'b1, 1'b0, 32'h3, 2'd0, 1'b1, 32'd0, rd, er);
        chk("b3_unsigned", rd, 32'h00000080);
        access(1'b0, 1'b0, 32'h2, 2'd1, 1'b0, 32'd0, rd, er);
        chk("h2_signed", rd, 32'hFFFF80FF);
        access(1'b0, 1'b0, 32'h1, 2'd0, 1'b0, 32'd0, rd, er);
        chk("b1_signed", rd, 32'h0000007F);

        step = "half_store";
        access(1'b0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h11223344, rd, er);
        access(1'b0, 1'b1, 32'h6, 2'd1, 1'b0, 32'h0000AB12, rd, er);
        if (wq_wd.size() > 0) chk("hs_wd", wq_wd[0], 32'hAB120000);
        access(1'b1, 1'b0, 32'h4, 2'd2, 1'b0, 32'd0, rd, er);
        chk("hs_reload", rd, 32'hAB123344);

        step = "errors";
        access(1'b0, 1'b0, 32'h2, 2'd2, 1'b0, 32'd0, rd, er);
        chk("word_misaligned", 32'(er), 32'd1);
        access(1'b1, 1'b1, 32'h5, 2'd1, 1'b0, 32'h1234, rd, er);
        chk("half_misaligned", 32'(er), 32'd1);
        access(1'b0, 1'b1, 32'h8, 2'd3, 1'b0, 32'h5555, rd, er);
        chk("size_illegal", 32'(er), 32'd1);
        access(1'b1, 1'b0, 32'h1000, 2'd2, 1'b0, 32'd0, rd, er);
        chk("out_of_range", 32'(er), 32'd1);

        step = "rst_mid_store";
        wq_a.delete(); wq_wm.delete(); wq_wd.delete();
        c_we = 1'b1; c_addr = 32'h20; c_size = 2'd2; c_uns = 1'b0; c_wdata = 32'h11223344; c_req = 1'b1;
        #1;
        chk("gnt", 32'(c_gnt), 32'd1);
        tick();
        c_req = 1'b0;
        chk("st1_wm", 32'(mem_wm), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk("we_in_rst", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0;
        chk("c_done", 32'(c_done), 32'd0);
        chk("mem_we", 32'(mem_we), 32'd0);
        chk("mem_wm", 32'(mem_wm), 32'd0);
        chk("mem_a", mem_a, 32'd0);
        chk("mem_wd", mem_wd, 32'd0);
        chk("c_rdata", c_rdata, 32'd0);
        tick();
        chk("c_done_late", 32'(c_done), 32'd0);
        chk("nwrites", 32'(wq_a.size()), 32'd1);
        chk("lane0_only", tb_mem[8], 32'h00000044);
        ref_mem[32'h20] = 8'h44;

        step = "tie";
        c_we = 1'b0; c_addr = 32'h10; c_size = 2'd2;
        l_we = 1'b0; l_addr = 32'h4; l_size = 2'd2;
        c_req = 1'b1; l_req = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) begin
                c_req = 1'b0; l_req = 1'b0;
            end
            #1;
            chk($sformatf("c_gnt%0d", i), 32'(c_gnt), 32'(i == 0 || i == 4));
            chk($sformatf("l_gnt%0d", i), 32'(l_gnt), 32'(i == 2));
            chk($sformatf("c_done%0d", i), 32'(c_done), 32'(i == 2 || i == 6));
            chk($sformatf("l_done%0d", i), 32'(l_done), 32'(i == 4));
            tick();
        end

        step = "random";
        for (int k = 0; k < 60; k++) begin
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 11) == 0) ra = ra | (32'd1 << $urandom_range(12, 31));
            access(p, w, ra, sz, u, $urandom, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
